// File: rtl/wb_sram_rr_arbiter_pkg.sv
// Shared types and helpers for the two-master Wishbone SRAM arbiter.
package wb_sram_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  // Number of byte-offset bits dropped when turning a byte address into a word address.
  function automatic int unsigned byte_offset_bits(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/wb_sram_arb_rr2.sv
// Combinational 2-way round-robin picker; a held lock restricts the choice to the owner.
module wb_sram_arb_rr2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       lock,
  input  logic       owner,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 1'b0;
    if (lock) begin
      gnt_valid = req[owner];
      gnt_idx   = owner;
    end else if (req == 2'b11) begin
      gnt_valid = 1'b1;
      gnt_idx   = ~last_grant;
    end else if (req != 2'b00) begin
      gnt_valid = 1'b1;
      gnt_idx   = req[1];
    end
  end

endmodule

// File: rtl/wb_sram_rr_arbiter.sv
// Two-master Wishbone round-robin arbiter in front of one byte-enable SRAM.
// Define WB_SRAM_ARB_LOCK_EN to keep the bus with a master while its cyc stays high.
module wb_sram_rr_arbiter
  import wb_sram_rr_arbiter_pkg::*;
#(
  parameter int unsigned ADR_WIDTH       = 32,
  parameter int unsigned SRAM_ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       m0_cyc,
  input  logic                       m0_stb,
  input  logic                       m0_we,
  input  logic [DATA_WIDTH/8-1:0]    m0_sel,
  input  logic [ADR_WIDTH-1:0]       m0_adr,
  input  logic [DATA_WIDTH-1:0]      m0_dat_w,
  output logic [DATA_WIDTH-1:0]      m0_dat_r,
  output logic                       m0_ack,
  output logic                       m0_err,
  input  logic                       m1_cyc,
  input  logic                       m1_stb,
  input  logic                       m1_we,
  input  logic [DATA_WIDTH/8-1:0]    m1_sel,
  input  logic [ADR_WIDTH-1:0]       m1_adr,
  input  logic [DATA_WIDTH-1:0]      m1_dat_w,
  output logic [DATA_WIDTH-1:0]      m1_dat_r,
  output logic                       m1_ack,
  output logic                       m1_err,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic                       sram_read_en,
  output logic                       sram_write_en,
  output logic [DATA_WIDTH/8-1:0]    sram_byte_en,
  output logic [DATA_WIDTH-1:0]      sram_write_data,
  input  logic [DATA_WIDTH-1:0]      sram_read_data
);

  localparam int unsigned B = byte_offset_bits(DATA_WIDTH);

  arb_state_e state_q, state_d;
  logic       last_grant_q;
  logic       grant_q;
  logic [1:0] req;
  logic       gnt_valid, gnt_idx;
  logic       lock, owner;

  logic                    g_we;
  logic [DATA_WIDTH/8-1:0] g_sel;
  logic [ADR_WIDTH-1:0]    g_adr;
  logic [DATA_WIDTH-1:0]   g_dat;
  logic                    unused_adr;

  assign req    = {m1_cyc & m1_stb, m0_cyc & m0_stb};
  assign g_we   = gnt_idx ? m1_we    : m0_we;
  assign g_sel  = gnt_idx ? m1_sel   : m0_sel;
  assign g_adr  = gnt_idx ? m1_adr   : m0_adr;
  assign g_dat  = gnt_idx ? m1_dat_w : m0_dat_w;
  assign unused_adr = ^g_adr;

  assign m0_dat_r = sram_read_data;
  assign m1_dat_r = sram_read_data;
  assign m0_err   = 1'b0;
  assign m1_err   = 1'b0;

`ifdef WB_SRAM_ARB_LOCK_EN
  logic locked_q, owner_q, owner_cyc;

  assign owner_cyc = owner_q ? m1_cyc : m0_cyc;
  // Lock only counts while the owner still holds cyc; the IDLE cycle that sees it low re-arbitrates.
  assign lock      = locked_q & owner_cyc;
  assign owner     = owner_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      locked_q <= 1'b0;
      owner_q  <= 1'b0;
    end else if (state_q == DONE) begin
      locked_q <= grant_q ? m1_cyc : m0_cyc;
      owner_q  <= grant_q;
    end else if (state_q == IDLE && !owner_cyc) begin
      locked_q <= 1'b0;
    end
  end
`else
  assign lock  = 1'b0;
  assign owner = 1'b0;
`endif

  wb_sram_arb_rr2 u_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .lock       (lock),
    .owner      (owner),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    unique case (state_q)
      IDLE:   if (gnt_valid) state_d = ACCESS;
      ACCESS: state_d = DONE;
      DONE: begin
        state_d = IDLE;
        m0_ack  = rstn & ~grant_q & m0_cyc & m0_stb;
        m1_ack  = rstn &  grant_q & m1_cyc & m1_stb;
      end
      default: state_d = IDLE;
    endcase
  end

  // Enables are registered on the grant edge so they are high exactly during ACCESS.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_grant_q    <= 1'b1;
      grant_q         <= 1'b0;
      sram_addr       <= '0;
      sram_read_en    <= 1'b0;
      sram_write_en   <= 1'b0;
      sram_byte_en    <= '0;
      sram_write_data <= '0;
    end else begin
      sram_read_en  <= 1'b0;
      sram_write_en <= 1'b0;
      if (state_q == IDLE && gnt_valid) begin
        grant_q         <= gnt_idx;
        sram_addr       <= g_adr[SRAM_ADDR_WIDTH+B-1:B];
        sram_byte_en    <= g_sel;
        sram_write_data <= g_dat;
        sram_read_en    <= ~g_we;
        sram_write_en   <= g_we;
      end
      if (state_q == DONE) last_grant_q <= grant_q;
    end
  end

endmodule
